// File: rtl/dram_read_streamer_if.sv
// rtl/dram_read_streamer_if.sv - handshake bundle for the DRAM read streamer
//
// Purpose: groups the job descriptor, DRAM request/response and PCIe packet
//          signals of dram_read_streamer into one bundle.
// Ports (master = streamer side):
//   job_*        descriptor in, job_ready out
//   mem_req_*    read request out, mem_req_grant in
//   mem_resp_*   read data in, mem_resp_grant out
//   pcie_out_*   packet out, pcie_grant_in in
//   job_done     completion pulse out
//   busy         streaming status out
`timescale 1ns/1ps
interface dram_read_streamer_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
) ();
   logic              job_valid;
   logic              job_ready;
   logic [ADDR_W-1:0] job_addr;
   logic [15:0]       job_beats;
   logic [15:0]       job_slot;
   logic [3:0]        job_pad;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_grant;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_data;
   logic              mem_resp_grant;
   logic              pcie_out_valid;
   logic [DATA_W-1:0] pcie_out_data;
   logic [15:0]       pcie_out_slot;
   logic [3:0]        pcie_out_pad;
   logic              pcie_out_last;
   logic              pcie_grant_in;
   logic              job_done;
   logic              busy;

   modport master (
      input  job_valid, job_addr, job_beats, job_slot, job_pad,
      input  mem_req_grant, mem_resp_valid, mem_resp_data, pcie_grant_in,
      output job_ready, mem_req_valid, mem_req_addr, mem_resp_grant,
      output pcie_out_valid, pcie_out_data, pcie_out_slot, pcie_out_pad,
      output pcie_out_last, job_done, busy
   );

   modport slave (
      output job_valid, job_addr, job_beats, job_slot, job_pad,
      output mem_req_grant, mem_resp_valid, mem_resp_data, pcie_grant_in,
      input  job_ready, mem_req_valid, mem_req_addr, mem_resp_grant,
      input  pcie_out_valid, pcie_out_data, pcie_out_slot, pcie_out_pad,
      input  pcie_out_last, job_done, busy
   );
endinterface

// File: rtl/dram_read_streamer.sv
// rtl/dram_read_streamer.sv - streams a DRAM result region out as PCIe packets
//
// Purpose: accepts one job (base, beats, slot, pad), issues sequential 64-byte
//          DRAM reads, buffers the in-order responses in a FIFO and emits one
//          PCIe packet per beat with last on the final beat. A credit counter
//          (requests granted but not yet sent) caps reads in flight plus
//          buffered at MAX_OUTSTANDING so the FIFO can never overflow.
// Ports:
//   clk    single clock
//   rst_n  asynchronous active-low reset
//   bus    dram_read_streamer_if.master (job, mem request/response, pcie out,
//          job_done, busy)
`timescale 1ns/1ps
module dram_read_streamer #(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 512,
   parameter int MAX_OUTSTANDING = 16,
   parameter int LOG_BUF_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   dram_read_streamer_if.master bus
);
   localparam int DEPTH = 1 << LOG_BUF_DEPTH;
   localparam int CW    = LOG_BUF_DEPTH + 1;

   typedef enum logic {IDLE, STREAM} state_t;
   state_t state, state_nxt;

   logic [ADDR_W-1:0] base_addr;
   logic [15:0]       beats, slot, issued, sent;
   logic [3:0]        pad;
   logic [CW-1:0]     credit;
   logic [CW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] buf_mem [DEPTH];
   logic              done_q;

   logic buf_empty, buf_full;
   logic job_take, req_valid, resp_grant, out_valid, out_last;
   logic req_fire, pkt_fire, last_fire;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign buf_empty = (wr_ptr == rd_ptr);
   assign buf_full  = (wr_ptr[LOG_BUF_DEPTH-1:0] == rd_ptr[LOG_BUF_DEPTH-1:0]) &&
                      (wr_ptr[LOG_BUF_DEPTH] != rd_ptr[LOG_BUF_DEPTH]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      job_take   = 1'b0;
      req_valid  = 1'b0;
      resp_grant = 1'b0;
      out_valid  = 1'b0;
      out_last   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.job_valid) begin
               job_take = 1'b1;
               // Zero-beat jobs complete from IDLE without any traffic.
               if (bus.job_beats != 16'd0) state_nxt = STREAM;
            end
         end
         STREAM: begin
            req_valid  = (issued < beats) && (credit < CW'(MAX_OUTSTANDING));
            resp_grant = bus.mem_resp_valid && !buf_full;
            out_valid  = !buf_empty;
            out_last   = out_valid && (sent == beats - 16'd1);
            if (out_last && bus.pcie_grant_in) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign req_fire  = req_valid && bus.mem_req_grant;
   assign pkt_fire  = out_valid && bus.pcie_grant_in;
   assign last_fire = out_last && bus.pcie_grant_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_addr <= '0;
         beats     <= '0;
         slot      <= '0;
         pad       <= '0;
         issued    <= '0;
         sent      <= '0;
         credit    <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= (job_take && (bus.job_beats == 16'd0)) || last_fire;
         if (job_take) begin
            base_addr <= bus.job_addr & ~ADDR_W'(6'h3F);
            beats     <= bus.job_beats;
            slot      <= bus.job_slot;
            pad       <= bus.job_pad;
            issued    <= '0;
            sent      <= '0;
            credit    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
         end else begin
            if (req_fire)   issued <= issued + 16'd1;
            if (pkt_fire)   sent   <= sent + 16'd1;
            if (resp_grant) wr_ptr <= wr_ptr + CW'(1);
            if (pkt_fire)   rd_ptr <= rd_ptr + CW'(1);
            // Issue and pop in the same cycle cancel out.
            case ({req_fire, pkt_fire})
               2'b10:   credit <= credit + CW'(1);
               2'b01:   credit <= credit - CW'(1);
               default: credit <= credit;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (resp_grant) buf_mem[wr_ptr[LOG_BUF_DEPTH-1:0]] <= bus.mem_resp_data;
   end

   assign bus.job_ready      = (state == IDLE);
   assign bus.busy           = (state == STREAM);
   assign bus.job_done       = done_q;
   assign bus.mem_req_valid  = req_valid;
   assign bus.mem_req_addr   = base_addr + {{(ADDR_W-22){1'b0}}, issued, 6'b0};
   assign bus.mem_resp_grant = resp_grant;
   assign bus.pcie_out_valid = out_valid;
   assign bus.pcie_out_data  = buf_mem[rd_ptr[LOG_BUF_DEPTH-1:0]];
   assign bus.pcie_out_slot  = slot;
   assign bus.pcie_out_pad   = pad;
   assign bus.pcie_out_last  = out_last;
endmodule

// File: tb/tb_dram_read_streamer.sv
// tb/tb_dram_read_streamer.sv - directed self-checking bench for dram_read_streamer
`timescale 1ns/1ps
module tb_dram_read_streamer;
   localparam int ADDR_W = 64;
   localparam int DATA_W = 512;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dram_read_streamer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   dram_read_streamer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(16), .LOG_BUF_DEPTH(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int lat = 1;
   bit req_grant_en = 1'b1;
   bit pcie_grant_en = 1'b1;
   int done_cnt = 0;

   logic [63:0]  mq_addr [$];
   int           mq_rdy  [$];
   logic [63:0]  req_log [$];
   int           req_cyc [$];
   int           acc_log [$];
   int           done_log[$];
   logic [511:0] pk_data [$];
   logic [15:0]  pk_slot [$];
   logic [3:0]   pk_pad  [$];
   logic         pk_last [$];
   int           pk_cyc  [$];

   function automatic logic [511:0] dfn(input logic [63:0] a);
      return {8{a ^ 64'h5A5A_C3C3_0F0F_9696}};
   endfunction

   // Memory / PCIe environment: drives at negedge, logs handshakes just before posedge.
   always @(negedge clk) begin
      cyc++;
      if (bus.job_done) begin
         done_cnt++;
         done_log.push_back(cyc);
      end
      if (!rst_n) begin
         mq_addr.delete();
         mq_rdy.delete();
      end
      bus.mem_req_grant = req_grant_en;
      bus.pcie_grant_in = pcie_grant_en;
      if (mq_addr.size() > 0 && mq_rdy[0] <= cyc) begin
         bus.mem_resp_valid = 1'b1;
         bus.mem_resp_data  = dfn(mq_addr[0]);
      end else begin
         bus.mem_resp_valid = 1'b0;
         bus.mem_resp_data  = '0;
      end
      #3;
      if (bus.job_valid && bus.job_ready) acc_log.push_back(cyc);
      if (bus.mem_req_valid && bus.mem_req_grant) begin
         req_log.push_back(bus.mem_req_addr);
         req_cyc.push_back(cyc);
         mq_addr.push_back(bus.mem_req_addr);
         mq_rdy.push_back(cyc + lat);
      end
      if (bus.mem_resp_valid && bus.mem_resp_grant) begin
         void'(mq_addr.pop_front());
         void'(mq_rdy.pop_front());
      end
      if (bus.pcie_out_valid && bus.pcie_grant_in) begin
         pk_data.push_back(bus.pcie_out_data);
         pk_slot.push_back(bus.pcie_out_slot);
         pk_pad.push_back(bus.pcie_out_pad);
         pk_last.push_back(bus.pcie_out_last);
         pk_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic clear_logs();
      req_log.delete(); req_cyc.delete(); acc_log.delete(); done_log.delete();
      pk_data.delete(); pk_slot.delete(); pk_pad.delete(); pk_last.delete();
      pk_cyc.delete();
   endtask

   task automatic job_go(input logic [63:0] a, input logic [15:0] b,
                         input logic [15:0] s, input logic [3:0] p);
      bus.job_addr  = a;
      bus.job_beats = b;
      bus.job_slot  = s;
      bus.job_pad   = p;
      bus.job_valid = 1'b1;
      step();
      bus.job_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input int maxc);
      int k = 0;
      while (done_cnt < target && k < maxc) begin
         step();
         k++;
      end
      chk("done_reached", done_cnt >= target, 1);
   endtask

   initial begin
      int d0;
      int k;
      bus.job_valid = 1'b0;
      bus.job_addr  = '0;
      bus.job_beats = '0;
      bus.job_slot  = '0;
      bus.job_pad   = '0;
      bus.mem_req_grant  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_data  = '0;
      bus.pcie_grant_in  = 1'b0;

      // Reset state
      repeat (3) step();
      chk("rst_job_ready", bus.job_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_req_valid", bus.mem_req_valid, 0);
      chk("rst_resp_grant", bus.mem_resp_grant, 0);
      chk("rst_out_valid", bus.pcie_out_valid, 0);
      chk("rst_out_last", bus.pcie_out_last, 0);
      chk("rst_job_done", bus.job_done, 0);
      rst_n = 1'b1;
      repeat (2) step();

      // Single beat, fastest memory
      lat = 0;
      clear_logs();
      d0 = done_cnt;
      job_go(64'h1000, 16'd1, 16'd5, 4'd0);
      wait_done(d0 + 1, 50);
      chk("one_ready_at_done", bus.job_ready, 1);
      chk("one_req_cnt", req_log.size(), 1);
      chk("one_req_addr", req_log[0], 64'h1000);
      chk("one_req_latency", req_cyc[0], acc_log[0] + 1);
      chk("one_pkt_cnt", pk_data.size(), 1);
      chk("one_pkt_last", pk_last[0], 1);
      chk("one_pkt_slot", pk_slot[0], 16'd5);
      chk("one_pkt_data", pk_data[0], dfn(64'h1000));
      chk("one_done_timing", done_log[0], pk_cyc[0] + 1);
      step();
      chk("one_done_pulse_ends", bus.job_done, 0);

      // 40-beat stream, latency 10
      lat = 10;
      clear_logs();
      d0 = done_cnt;
      job_go(64'h0, 16'd40, 16'd7, 4'd2);
      wait_done(d0 + 1, 2000);
      chk("strm_req_cnt", req_log.size(), 40);
      chk("strm_pkt_cnt", pk_data.size(), 40);
      for (int i = 0; i < 40; i++) begin
         chk($sformatf("strm_addr%0d", i), req_log[i], 64'(i * 64));
         chk($sformatf("strm_data%0d", i), pk_data[i], dfn(64'(i * 64)));
         chk($sformatf("strm_last%0d", i), pk_last[i], (i == 39) ? 1'b1 : 1'b0);
      end
      chk("strm_pad", pk_pad[20], 4'd2);

      // Backpressure: 16-read credit limit
      lat = 3;
      pcie_grant_en = 1'b0;
      clear_logs();
      d0 = done_cnt;
      job_go(64'h4000, 16'd32, 16'd9, 4'd1);
      repeat (200) step();
      chk("bp_req_cnt", req_log.size(), 16);
      chk("bp_req_valid_low", bus.mem_req_valid, 0);
      chk("bp_mem_drained", mq_addr.size(), 0);
      chk("bp_pkt_cnt", pk_data.size(), 0);
      chk("bp_out_valid", bus.pcie_out_valid, 1);
      chk("bp_out_hold", bus.pcie_out_data, dfn(64'h4000));
      chk("bp_out_last", bus.pcie_out_last, 0);
      pcie_grant_en = 1'b1;
      wait_done(d0 + 1, 1000);
      chk("bp_req_total", req_log.size(), 32);
      chk("bp_pkt_total", pk_data.size(), 32);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("bp_data%0d", i), pk_data[i], dfn(64'h4000 + 64'(i * 64)));
         chk($sformatf("bp_last%0d", i), pk_last[i], (i == 31) ? 1'b1 : 1'b0);
      end

      // Zero-beat job then 3-beat job back to back
      lat = 1;
      clear_logs();
      d0 = done_cnt;
      job_go(64'h2000, 16'd0, 16'd1, 4'd1);
      job_go(64'h3000, 16'd3, 16'd2, 4'd3);
      wait_done(d0 + 2, 200);
      chk("b2b_acc_cnt", acc_log.size(), 2);
      chk("b2b_acc_adjacent", acc_log[1], acc_log[0] + 1);
      chk("b2b_zero_done", done_log[0], acc_log[0] + 1);
      chk("b2b_req_cnt", req_log.size(), 3);
      chk("b2b_req0", req_log[0], 64'h3000);
      chk("b2b_pkt_cnt", pk_data.size(), 3);
      chk("b2b_last0", pk_last[0], 0);
      chk("b2b_last1", pk_last[1], 0);
      chk("b2b_last2", pk_last[2], 1);
      chk("b2b_slot", pk_slot[2], 16'd2);
      chk("b2b_pad", pk_pad[2], 4'd3);
      chk("b2b_data2", pk_data[2], dfn(64'h3080));

      // Address wrap
      clear_logs();
      d0 = done_cnt;
      job_go(64'hFFFF_FFFF_FFFF_FFC0, 16'd2, 16'd3, 4'd0);
      wait_done(d0 + 1, 200);
      chk("wrap_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFC0);
      chk("wrap_req1", req_log[1], 64'h0);
      chk("wrap_data1", pk_data[1], dfn(64'h0));

      // Reset after 5 of 20 packets
      lat = 2;
      clear_logs();
      d0 = done_cnt;
      job_go(64'h8000, 16'd20, 16'd4, 4'd5);
      k = 0;
      while (pk_data.size() < 5 && k < 500) begin
         step();
         k++;
      end
      chk("mid_pkts_before_rst", pk_data.size(), 5);
      rst_n = 1'b0;
      #1;
      chk("mid_req_valid", bus.mem_req_valid, 0);
      chk("mid_resp_grant", bus.mem_resp_grant, 0);
      chk("mid_out_valid", bus.pcie_out_valid, 0);
      chk("mid_out_last", bus.pcie_out_last, 0);
      chk("mid_job_done", bus.job_done, 0);
      chk("mid_busy", bus.busy, 0);
      chk("mid_job_ready", bus.job_ready, 1);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("mid_no_done", done_cnt, d0);
      clear_logs();
      job_go(64'h9000, 16'd4, 16'd6, 4'd7);
      wait_done(d0 + 1, 200);
      chk("post_pkt_cnt", pk_data.size(), 4);
      chk("post_data0", pk_data[0], dfn(64'h9000));
      chk("post_data3", pk_data[3], dfn(64'h90C0));
      chk("post_last3", pk_last[3], 1);
      chk("post_slot", pk_slot[0], 16'd6);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
